// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int INDEX_W_DEF = 8;
    localparam int ADDR_W_DEF  = 32;
    localparam int TAG_W_DEF   = ADDR_W_DEF - INDEX_W_DEF - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RESP
    } state_e;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w - 2;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped lines: one async read port, one write port.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk_in) begin
        if (rst_in)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= 1'b1;
    end

    // Tag and data need no reset; the valid bit gates every use.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with a byte-wide refill port.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_ready,
    input  logic              flush,
    output logic              ic_valid,
    output logic [31:0]       ic_instr,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_din
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_W);

    state_e              state_q, state_d;
    logic [ADDR_W-1:2]   pc_q;
    logic [2:0]          k_q;
    logic                pend_q;
    logic [1:0]          pend_k_q;
    logic [2:0]          rcv_q, rcv_n;
    logic [31:0]         buf_q, buf_n;
    logic                vld_q;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [31:0]         rd_data;
    logic                hit, accept, issue, arrive, fill_done;
    logic                unused_pc;

    assign unused_pc = ^if_pc[1:0];

    icache_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_idx   (if_pc[INDEX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_done),
        .wr_idx   (pc_q[INDEX_W+1:2]),
        .wr_tag   (pc_q[ADDR_W-1:INDEX_W+2]),
        .wr_data  (buf_n)
    );

    assign if_ready = (state_q == S_IDLE);
    assign accept   = rdy_in && !flush && if_valid && (state_q == S_IDLE);
    assign hit      = rd_valid && (rd_tag == if_pc[ADDR_W-1:INDEX_W+2]);

    assign mem_rd   = rdy_in && !flush && (state_q == S_FILL) && !k_q[2];
    assign mem_a    = {pc_q, k_q[1:0]};
    assign issue    = mem_rd && mem_gnt;

    // A byte in flight is captured only if the fill is still live when it lands.
    assign arrive   = pend_q && (state_q == S_FILL);
    assign rcv_n    = rcv_q + {2'b00, arrive};

    always_comb begin
        buf_n = buf_q;
        if (arrive)
            buf_n[{pend_k_q, 3'b000} +: 8] = mem_din;
    end

    assign fill_done = rdy_in && !flush && (state_q == S_FILL) && (rcv_n == 3'd4);
    assign ic_valid  = vld_q && !flush;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = hit ? S_RESP : S_FILL;
                S_FILL:  if (fill_done) state_d = S_RESP;
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            k_q      <= '0;
            pend_q   <= 1'b0;
            pend_k_q <= '0;
            rcv_q    <= '0;
            buf_q    <= '0;
            vld_q    <= 1'b0;
            ic_instr <= '0;
        end else begin
            pend_q <= issue;
            if (issue)
                pend_k_q <= k_q[1:0];
            if (arrive) begin
                buf_q <= buf_n;
                rcv_q <= rcv_n;
            end
            if (rdy_in) begin
                state_q <= state_d;
                vld_q   <= 1'b0;
                if (accept) begin
                    pc_q  <= if_pc[ADDR_W-1:2];
                    k_q   <= '0;
                    rcv_q <= '0;
                    if (hit) begin
                        vld_q    <= 1'b1;
                        ic_instr <= rd_data;
                    end
                end
                if (issue)
                    k_q <= k_q + 3'd1;
                if (fill_done) begin
                    vld_q    <= 1'b1;
                    ic_instr <= buf_n;
                end
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (hit)
                hit_cnt <= hit_cnt + 32'd1;
            else
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboarded bench for icache: a line-residency model predicts hit/miss and memory
// contents predict the returned word; a monitor checks every ic_valid pulse.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ic_valid;
    logic [31:0] ic_instr;
    logic [31:0] mem_a;
    logic        mem_rd;
    logic        mem_gnt;
    logic [7:0]  mem_din;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_ready (if_ready),
        .flush    (flush),
        .ic_valid (ic_valid),
        .ic_instr (ic_instr),
        .mem_a    (mem_a),
        .mem_rd   (mem_rd),
        .mem_gnt  (mem_gnt),
        .mem_din  (mem_din)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int m_hits  = 0;
    int m_miss  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] iss_q[$];
    bit          res_v [256];
    logic [21:0] res_t [256];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ram(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h00;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] base);
        return {ram(base + 3), ram(base + 2), ram(base + 1), ram(base)};
    endfunction

    // Memory: a granted read returns its byte in the following cycle.
    always begin
        logic        have;
        logic [7:0]  nxt;
        @(negedge clk_in);
        have = 1'b0;
        nxt  = 8'h00;
        if (!rst_in && mem_rd && mem_gnt) begin
            iss_q.push_back(mem_a);
            nxt  = ram(mem_a);
            have = 1'b1;
        end
        @(posedge clk_in);
        #1;
        mem_din = have ? nxt : 8'($urandom);
    end

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (!rst_in && ic_valid) begin
            if (exp_q.size() == 0) begin
                chk("stray_ic_valid", {32'd0, ic_instr}, 64'hDEAD);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("ic_instr", {32'd0, ic_instr}, {32'd0, e});
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!if_ready && n < 20) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (!if_ready) chk("if_ready_timeout", 0, 1);
    endtask

    task automatic fetch(input logic [31:0] pc, input int flush_c, input int gs, input int gn,
                         input int rs, input int rn, input bit rnd_gnt, input int exp_lat);
        logic [7:0]  idx;
        logic [21:0] tag;
        logic [31:0] base;
        bit          hit, kill, done;
        int          lat;
        idx  = pc[9:2];
        tag  = pc[31:10];
        base = {pc[31:2], 2'b00};
        hit  = res_v[idx] && (res_t[idx] == tag);
        kill = (flush_c > 0);
        wait_ready();
        iss_q.delete();
        if_valid = 1'b1;
        if_pc    = pc;
        mem_gnt  = 1'b1;
        rdy_in   = 1'b1;
        if (!kill) exp_q.push_back(word_at(base));
        if (hit) m_hits++; else m_miss++;
        @(posedge clk_in);
        #1;
        if_valid = 1'b0;
        lat  = -1;
        done = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            flush   = (c == flush_c);
            rdy_in  = !(c >= rs && c < rs + rn);
            mem_gnt = rnd_gnt ? ($urandom_range(3) != 0) : !(c >= gs && c < gs + gn);
            @(negedge clk_in);
            if (!rdy_in) chk("mem_rd_when_stalled", {63'd0, mem_rd}, 0);
            if (ic_valid && lat < 0) lat = c;
            @(posedge clk_in);
            #1;
            flush = 1'b0;
            if (kill ? (c >= flush_c + 6) : (lat >= 0)) done = 1'b1;
        end
        rdy_in  = 1'b1;
        mem_gnt = 1'b1;
        if (kill) begin
            chk("flush_no_valid", lat, -1);
        end else begin
            if (lat < 0) chk("response_timeout", 0, 1);
            if (hit) chk("hit_latency", lat, 1);
            else if (exp_lat >= 0) chk("miss_latency", lat, exp_lat);
            chk("issue_count", iss_q.size(), hit ? 0 : 4);
        end
        foreach (iss_q[i]) chk("issue_addr", {32'd0, iss_q[i]}, {32'd0, base + 32'(i)});
        if (!hit && !kill) begin
            res_v[idx] = 1'b1;
            res_t[idx] = tag;
        end
    endtask

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        if_valid = 1'b0;
        if_pc    = '0;
        flush    = 1'b0;
        mem_gnt  = 1'b1;
        mem_din  = '0;
        foreach (res_v[i]) res_v[i] = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ic_valid", {63'd0, ic_valid}, 0);
        chk("rst_ic_instr", {32'd0, ic_instr}, 0);
        chk("rst_mem_rd",   {63'd0, mem_rd}, 0);
        chk("rst_mem_a",    {32'd0, mem_a}, 0);
        chk("rst_if_ready", {63'd0, if_ready}, 1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        fetch(32'h0000_0000, 0, 0, 0, 0, 0, 0, 6);
        fetch(32'h0000_0000, 0, 0, 0, 0, 0, 0, 1);
        fetch(32'h0000_0400, 0, 0, 0, 0, 0, 0, 6);
        fetch(32'h0000_0000, 0, 0, 0, 0, 0, 0, 6);
        fetch(32'h0000_1004, 0, 3, 3, 0, 0, 0, 9);
        fetch(32'h0000_2008, 3, 0, 0, 0, 0, 0, -1);
        fetch(32'h0000_2008, 0, 0, 0, 0, 0, 0, 6);
        fetch(32'h0000_300C, 0, 0, 0, 2, 3, 0, 9);

        // A request coinciding with flush must be ignored even though it would hit.
        wait_ready();
        if_valid = 1'b1;
        if_pc    = 32'h0000_0000;
        flush    = 1'b1;
        @(posedge clk_in);
        #1;
        if_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk_in);
        chk("flush_reject_valid",  {63'd0, ic_valid}, 0);
        chk("flush_reject_mem_rd", {63'd0, mem_rd}, 0);
        chk("flush_reject_ready",  {63'd0, if_ready}, 1);
        @(posedge clk_in);
        #1;

        for (int n = 0; n < 60; n++) begin
            logic [21:0] tg;
            logic [7:0]  ix;
            logic [31:0] pc;
            bit          h;
            int          fc;
            case ($urandom_range(3))
                0: tg = 22'h000000;
                1: tg = 22'h000001;
                2: tg = 22'h3FFFFF;
                default: tg = 22'h015555;
            endcase
            ix = ($urandom_range(1) == 1) ? 8'($urandom_range(5)) : 8'(8'hFF - $urandom_range(1));
            pc = {tg, ix, 2'($urandom)};
            h  = res_v[ix] && (res_t[ix] == tg);
            fc = (!h && $urandom_range(9) == 0) ? int'($urandom_range(4, 1)) : 0;
            fetch(pc, fc, 0, 0, 0, 0, 1, -1);
        end

`ifdef ICACHE_PERF_CNT_EN
        chk("hit_cnt",  {32'd0, hit_cnt},  m_hits);
        chk("miss_cnt", {32'd0, miss_cnt}, m_miss);
`endif

        // Reset must drop every line.
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        foreach (res_v[i]) res_v[i] = 1'b0;
        fetch(32'h0000_0000, 0, 0, 0, 0, 0, 0, 6);

        repeat (3) @(posedge clk_in);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
